// File: rtl/wallace_seq8.sv
// wallace_seq8: sequenced 8x8 multiplier. It reuses one combinational 4x4
// Wallace-tree multiplier (wallace4) for four nibble passes and accumulates
// the shifted partial products into a 16-bit result.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake (in_ready is combinational)
//   in_a, in_b, in_signed operands and signed-mode select, sampled on accept
//   abort                 synchronous cancel, highest priority
//   out_valid/out_ready   result handshake
//   out_p                 16-bit product, two's complement in signed mode
//   busy                  controller not idle

// wallace4: combinational 4x4 unsigned multiplier, two carry-save levels
// followed by one carry-propagate add.
module wallace4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_r0, w_r1, w_r2, w_r3;
  logic [7:0] w_s1, w_c1, w_s2, w_c2;

  // Partial-product rows, each pre-shifted to its column weight.
  assign w_r0 = {4'b0000, i_a & {4{i_b[0]}}};
  assign w_r1 = {3'b000, i_a & {4{i_b[1]}}, 1'b0};
  assign w_r2 = {2'b00, i_a & {4{i_b[2]}}, 2'b00};
  assign w_r3 = {1'b0, i_a & {4{i_b[3]}}, 3'b000};

  // First 3:2 level over rows 0..2.
  assign w_s1 = w_r0 ^ w_r1 ^ w_r2;
  assign w_c1 = ((w_r0 & w_r1) | (w_r0 & w_r2) | (w_r1 & w_r2)) << 1;

  // Second 3:2 level folds in row 3.
  assign w_s2 = w_s1 ^ w_c1 ^ w_r3;
  assign w_c2 = ((w_s1 & w_c1) | (w_s1 & w_r3) | (w_c1 & w_r3)) << 1;

  // The product never exceeds 225, so the 8-bit sum cannot wrap.
  assign o_p = w_s2 + w_c2;
endmodule

module wallace_seq8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_signed,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy
);
  localparam int unsigned W_OP  = 8;
  localparam int unsigned W_P   = 16;
  localparam int unsigned W_NIB = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_step;
  logic [W_OP-1:0]    r_ma, r_mb;
  logic               r_neg;
  logic [W_P-1:0]     r_acc;
  logic [W_P-1:0]     r_out_p;

  logic               w_accept;
  logic [W_NIB-1:0]   w_na, w_nb;
  logic [3:0]         w_shift;
  logic [W_OP-1:0]    w_pp8;
  logic [W_P-1:0]     w_sum;
  logic [W_P-1:0]     w_res;
  logic [W_OP-1:0]    w_mag_a, w_mag_b;

  assign in_ready  = (r_state == IDLE) && !abort;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_p     = r_out_p;

  // Magnitudes; 0x80 negates to 0x80, which reads correctly as unsigned 128.
  assign w_mag_a = (in_signed && in_a[W_OP-1]) ? (~in_a + 8'd1) : in_a;
  assign w_mag_b = (in_signed && in_b[W_OP-1]) ? (~in_b + 8'd1) : in_b;

  // Nibble selection and shift for the current pass.
  always_comb begin
    w_na    = r_ma[3:0];
    w_nb    = r_mb[3:0];
    w_shift = 4'd0;
    case (r_step)
      2'd0: begin w_na = r_ma[3:0]; w_nb = r_mb[3:0]; w_shift = 4'd0; end
      2'd1: begin w_na = r_ma[7:4]; w_nb = r_mb[3:0]; w_shift = 4'd4; end
      2'd2: begin w_na = r_ma[3:0]; w_nb = r_mb[7:4]; w_shift = 4'd4; end
      default: begin w_na = r_ma[7:4]; w_nb = r_mb[7:4]; w_shift = 4'd8; end
    endcase
  end

  wallace4 u_wallace4 (
    .i_a (w_na),
    .i_b (w_nb),
    .o_p (w_pp8)
  );

  assign w_sum = r_acc + (W_P'(w_pp8) << w_shift);
  assign w_res = r_neg ? (~w_sum + 16'd1) : w_sum;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = MUL;
      MUL:     if (r_step == 2'd3) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // Operand capture, accumulation and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step  <= 2'd0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_out_p <= '0;
    end else if (abort) begin
      r_step <= 2'd0;
      r_acc  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_ma   <= w_mag_a;
          r_mb   <= w_mag_b;
          r_neg  <= in_signed && (in_a[W_OP-1] ^ in_b[W_OP-1]);
          r_acc  <= '0;
          r_step <= 2'd0;
        end
        MUL: begin
          r_acc  <= w_sum;
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) r_out_p <= w_res;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wallace_seq8.sv
// tb_wallace_seq8: directed and random self-checking bench for wallace_seq8.
module tb_wallace_seq8;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic        in_signed;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int results = 0;
  int lost = 0;

  wallace_seq8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Handshake counters for the one-result-per-accept check.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready)   accepts <= accepts + 1;
    if (rst_n && out_valid && out_ready) results <= results + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    int pa, pb;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    return 16'(pa * pb);
  endfunction

  // Issue one op, wait for its result, stall, then complete the handshake.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp, input int stall,
                       input bit chk_lat);
    int n;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_signed = ~s;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    if (chk_lat) check({tag, "_latency"}, 32'(n), 32'd4);
    check(tag, 32'(out_p), 32'(exp));
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    logic [7:0]  ra, rb;
    logic        rs;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);

    // Unsigned corners.
    do_op("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, 1'b1);
    do_op("u_80_01", 8'h80, 8'h01, 1'b0, 16'h0080, 0, 1'b0);
    do_op("u_00_a5", 8'h00, 8'hA5, 1'b0, 16'h0000, 0, 1'b0);
    do_op("u_ff_fe", 8'hFF, 8'hFE, 1'b0, 16'hFD02, 0, 1'b0);

    // Reset mid-MUL at step 2 kills the op and clears out_p immediately.
    in_a = 8'h77; in_b = 8'h33; in_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_p", 32'(out_p), 32'd0);
    lost++;
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    do_op("u_12_34", 8'h12, 8'h34, 1'b0, 16'h03A8, 0, 1'b1);

    // Signed cases.
    do_op("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000, 0, 1'b1);
    do_op("s_80_01", 8'h80, 8'h01, 1'b1, 16'hFF80, 0, 1'b0);
    do_op("s_fd_05", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, 1'b0);
    do_op("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001, 0, 1'b0);
    do_op("s_07_f9", 8'h07, 8'hF9, 1'b1, 16'hFFCF, 0, 1'b0);

    // Backpressure: result frozen, pending request not taken, then accepted.
    in_a = 8'h0F; in_b = 8'h11; in_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_p", 32'(out_p), 32'h00FF);
    in_a = 8'h03; in_b = 8'h05; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_p", 32'(out_p), 32'h00FF);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_accept_busy", 32'(busy), 32'd1);
    repeat (4) tick();
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_p", 32'(out_p), 32'h000F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Abort during MUL step 1: no result, idle once abort drops.
    held = out_p;
    in_a = 8'h55; in_b = 8'h66; in_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    abort = 1'b1;
    #1;
    check("ab_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    abort = 1'b0;
    #1;
    check("ab_idle_busy", 32'(busy), 32'd0);
    check("ab_idle_in_ready", 32'(in_ready), 32'd1);
    lost++;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (out_valid) seen = 1'b1;
        tick();
      end
      check("ab_no_valid", 32'(seen), 32'd0);
    end
    check("ab_out_p_kept", 32'(out_p), 32'(held));

    // Abort in DONE: valid drops, out_p retained.
    in_a = 8'h0A; in_b = 8'h0B; in_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abd_valid", 32'(out_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abd_valid_drop", 32'(out_valid), 32'd0);
    check("abd_out_p", 32'(out_p), 32'h006E);
    lost++;

    // Random ops with random result stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      do_op("rand", ra, rb, rs, ref_mul(ra, rb, rs), int'($urandom_range(0, 3)), 1'b0);
    end

    tick();
    check("results_per_accept", 32'(results), 32'(accepts - lost));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
